// File: rtl/apb_i2c_ctrl.sv
// APB-slave I2C master: prescaled quarter-bit sequencer that issues
// START / one byte (read or write) / STOP per command and flags completion.
module apb_i2c_ctrl #(
    parameter int APB_ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    output logic                      interrupt_o,
    input  logic                      scl_pad_i,
    output logic                      scl_pad_o,
    output logic                      scl_padoen_o,
    input  logic                      sda_pad_i,
    output logic                      sda_pad_o,
    output logic                      sda_padoen_o
);

    typedef enum logic [1:0] {PH_IDLE, PH_START, PH_DATA, PH_STOP} phase_e;

    phase_e      phase, phase_d;
    logic [15:0] pre, qcnt;
    logic [7:0]  tx, rx, sr;
    logic [3:0]  bitcnt;
    logic [1:0]  quarter;
    logic        en, ien, rxack, busy, tip, irq_f, smp;
    logic        c_sto, c_rd, c_wr, c_ack;
    logic        scl_hold, sda_hold, scl_want, sda_want;
    logic        done, q_end, last_q, bit_last, data_bit;
    logic        apb_wr, wr_pre, wr_ctr, wr_tx, wr_cmd, cmd_go, abort;
    logic        unused;

    assign apb_wr = PSEL & PENABLE & PWRITE;
    assign wr_pre = apb_wr && (PADDR[4:2] == 3'd0);
    assign wr_ctr = apb_wr && (PADDR[4:2] == 3'd1);
    assign wr_tx  = apb_wr && (PADDR[4:2] == 3'd4);
    assign wr_cmd = apb_wr && (PADDR[4:2] == 3'd5);
    assign cmd_go = wr_cmd && en && !tip && (|PWDATA[7:4]);
    // Clearing EN kills any transfer and frees the bus.
    assign abort  = wr_ctr && !PWDATA[7] && en;

    assign q_end    = tip && (qcnt >= pre);
    assign last_q   = q_end && (quarter == 2'd3);
    assign bit_last = (bitcnt == 4'd8);
    // Write drives TX MSB-first and releases for ACK; read releases data bits
    // and drives the programmed ACK level.
    assign data_bit = bit_last ? (c_wr ? 1'b1 : c_ack) : (c_wr ? sr[7] : 1'b1);

    assign PREADY       = 1'b1;
    assign PSLVERR      = 1'b0;
    assign scl_pad_o    = 1'b0;
    assign sda_pad_o    = 1'b0;
    // Lines follow the sequencer while busy, otherwise keep the last level.
    assign scl_padoen_o = tip ? scl_want : scl_hold;
    assign sda_padoen_o = tip ? sda_want : sda_hold;
    assign interrupt_o  = irq_f & ien;
    assign unused = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0], PWDATA[31:16], scl_pad_i};

    // Register read mux, combinational on the address.
    always_comb begin
        PRDATA = 32'h0;
        case (PADDR[4:2])
            3'd0: PRDATA = {16'h0, pre};
            3'd1: PRDATA = {24'h0, en, ien, 6'h0};
            3'd2: PRDATA = {24'h0, rx};
            3'd3: PRDATA = {24'h0, rxack, busy, 1'b0, 3'b0, tip, irq_f};
            3'd4: PRDATA = {24'h0, tx};
            default: PRDATA = 32'h0;
        endcase
    end

    // Phase register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) phase <= PH_IDLE;
        else         phase <= phase_d;
    end

    // Per-quarter line levels and phase sequencing.
    always_comb begin
        phase_d  = phase;
        done     = 1'b0;
        scl_want = 1'b1;
        sda_want = 1'b1;
        case (phase)
            PH_START: begin
                sda_want = (quarter == 2'd0);
                scl_want = (quarter != 2'd3);
                if (last_q) begin
                    if (c_wr | c_rd) phase_d = PH_DATA;
                    else if (c_sto)  phase_d = PH_STOP;
                    else             done    = 1'b1;
                end
            end
            PH_DATA: begin
                scl_want = (quarter == 2'd1) || (quarter == 2'd2);
                sda_want = data_bit;
                if (last_q && bit_last) begin
                    if (c_sto) phase_d = PH_STOP;
                    else       done    = 1'b1;
                end
            end
            PH_STOP: begin
                scl_want = (quarter != 2'd0);
                sda_want = quarter[1];
                if (last_q) done = 1'b1;
            end
            default: ;
        endcase
        if (done) phase_d = PH_IDLE;
        if (cmd_go) phase_d = PWDATA[7] ? PH_START : ((|PWDATA[5:4]) ? PH_DATA : PH_STOP);
        if (abort) phase_d = PH_IDLE;
    end

    // Registers, prescaler, bit shifter and completion status.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pre <= 16'hFFFF; en <= 1'b0; ien <= 1'b0; tx <= 8'h0; rx <= 8'h0;
            rxack <= 1'b0; busy <= 1'b0; tip <= 1'b0; irq_f <= 1'b0;
            c_sto <= 1'b0; c_rd <= 1'b0; c_wr <= 1'b0; c_ack <= 1'b0;
            qcnt <= 16'h0; quarter <= 2'd0; bitcnt <= 4'd0; sr <= 8'h0; smp <= 1'b0;
            scl_hold <= 1'b1; sda_hold <= 1'b1;
        end else begin
            if (wr_pre) pre <= PWDATA[15:0];
            if (wr_ctr) {en, ien} <= PWDATA[7:6];
            if (wr_tx)  tx <= PWDATA[7:0];
            if (tip) begin
                qcnt     <= q_end ? 16'h0 : qcnt + 16'd1;
                scl_hold <= scl_want;
                sda_hold <= sda_want;
                if (q_end) quarter <= quarter + 2'd1;
            end
            if (q_end && phase == PH_DATA && quarter == 2'd2) begin
                smp <= sda_pad_i;
                if (bit_last && c_wr) rxack <= sda_pad_i;
            end
            if (last_q && phase == PH_DATA) begin
                bitcnt <= bit_last ? 4'd0 : bitcnt + 4'd1;
                if (!bit_last) sr <= {sr[6:0], smp};
                if (bitcnt == 4'd7 && c_rd) rx <= {sr[6:0], smp};
            end
            if (last_q && phase == PH_START) busy <= 1'b1;
            if (last_q && phase == PH_STOP)  busy <= 1'b0;
            if (done) tip <= 1'b0;
            // Completion wins over a simultaneous IACK.
            if (done)                       irq_f <= 1'b1;
            else if (wr_cmd && PWDATA[0])   irq_f <= 1'b0;
            if (cmd_go) begin
                tip     <= 1'b1;
                c_sto   <= PWDATA[6];
                c_wr    <= PWDATA[4];
                c_rd    <= PWDATA[5] & ~PWDATA[4];
                c_ack   <= PWDATA[3];
                qcnt    <= 16'h0;
                quarter <= 2'd0;
                bitcnt  <= 4'd0;
                sr      <= tx;
            end
            if (abort) begin
                tip      <= 1'b0;
                busy     <= 1'b0;
                scl_hold <= 1'b1;
                sda_hold <= 1'b1;
                if (done) irq_f <= irq_f;
            end
        end
    end

endmodule

// File: tb/tb_apb_i2c_ctrl.sv
// Bench for apb_i2c_ctrl: APB driver, wired-AND bus with a small slave model,
// and queues of expected read data and SDA bit values.
module tb_apb_i2c_ctrl;

    localparam int SM_NONE = 0, SM_ACK = 1, SM_RD = 2;

    logic        clk, rst_ni;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR, interrupt_o;
    logic        scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
    logic        scl_line, sda_line, sda_slv_oen;

    int          errs = 0, checks = 0;
    int          smode = SM_NONE;
    int          fcnt = -1;
    logic [7:0]  slv_data = 8'h00;
    logic [31:0] rd_q[$];
    logic        bit_q[$];
    int          n;

    assign scl_line = scl_padoen_o;
    assign sda_line = sda_padoen_o & sda_slv_oen;

    apb_i2c_ctrl #(.APB_ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .interrupt_o(interrupt_o),
        .scl_pad_i(scl_line), .scl_pad_o(scl_pad_o), .scl_padoen_o(scl_padoen_o),
        .sda_pad_i(sda_line), .sda_pad_o(sda_pad_o), .sda_padoen_o(sda_padoen_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge clk); #1 PENABLE = 1'b1;
        @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, input logic [31:0] exp, input logic [31:0] mask);
        rd_q.push_back(exp);
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge clk); #1 PENABLE = 1'b1;
        #1;
        chk($sformatf("rd_%02h", a), PRDATA & mask, rd_q.pop_front());
        chk("pready", {31'h0, PREADY}, 32'h1);
        chk("pslverr", {31'h0, PSLVERR}, 32'h0);
        @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Cycles with TIP high, observed through the STATUS read mux.
    task automatic wait_tip(output int cnt);
        cnt = 0;
        PADDR = 32'h0C;
        #1;
        while (PRDATA[1] === 1'b1 && cnt < 5000) begin
            cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic push_bits(input logic [8:0] b);
        for (int i = 8; i >= 0; i--) bit_q.push_back(b[i]);
    endtask

    // START condition restarts the slave's SCL-fall counter.
    always @(negedge sda_line) if (scl_line === 1'b1) fcnt = -1;

    // Slave changes SDA only while SCL is low.
    always @(negedge scl_line) begin
        fcnt++;
        case (smode)
            SM_ACK: if (fcnt == 8) sda_slv_oen = 1'b0; else if (fcnt == 9) sda_slv_oen = 1'b1;
            SM_RD:  if (fcnt >= 0 && fcnt <= 7) sda_slv_oen = slv_data[7 - fcnt];
                    else if (fcnt == 8) sda_slv_oen = 1'b1;
            default: sda_slv_oen = 1'b1;
        endcase
    end

    // Each SCL high phase with a pending expectation checks the bus bit.
    always @(posedge scl_line) begin
        if (bit_q.size() != 0) chk("sda_bit", {31'h0, sda_line}, {31'h0, bit_q.pop_front()});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; PADDR = 32'h0; PWDATA = 32'h0; PWRITE = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; sda_slv_oen = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Reset state
        chk("rst_scl_oen", {31'h0, scl_padoen_o}, 32'h1);
        chk("rst_sda_oen", {31'h0, sda_padoen_o}, 32'h1);
        chk("rst_irq", {31'h0, interrupt_o}, 32'h0);
        apb_read(32'h00, 32'h0000FFFF, 32'hFFFFFFFF);
        apb_read(32'h04, 32'h0, 32'hFFFFFFFF);
        apb_read(32'h08, 32'h0, 32'hFFFFFFFF);
        apb_read(32'h0C, 32'h0, 32'hFFFFFFFF);
        apb_read(32'h10, 32'h0, 32'hFFFFFFFF);
        apb_read(32'h14, 32'h0, 32'hFFFFFFFF);

        // START + write 0xA5 + STOP, slave ACKs
        smode = SM_ACK;
        apb_write(32'h00, 32'h1);
        apb_write(32'h04, 32'h80);
        apb_write(32'h10, 32'hA5);
        apb_read(32'h00, 32'h1, 32'hFFFFFFFF);
        apb_read(32'h10, 32'hA5, 32'hFFFFFFFF);
        push_bits(9'b1010_0101_0);
        apb_write(32'h14, 32'hD0);
        wait_tip(n);
        chk("tip_len_wr", n, 88);
        chk("bits_left_wr", bit_q.size(), 0);
        apb_read(32'h0C, 32'h01, 32'hFFFFFFFF);
        chk("end_scl_oen", {31'h0, scl_padoen_o}, 32'h1);
        chk("end_sda_oen", {31'h0, sda_padoen_o}, 32'h1);
        chk("irq_masked", {31'h0, interrupt_o}, 32'h0);

        // Same write, nobody answers
        smode = SM_NONE;
        apb_write(32'h14, 32'h01);
        apb_read(32'h0C, 32'h00, 32'hFFFFFFFF);
        bit_q.delete();
        push_bits(9'b1010_0101_1);
        apb_write(32'h14, 32'hD0);
        wait_tip(n);
        chk("tip_len_nack", n, 88);
        chk("bits_left_nack", bit_q.size(), 0);
        apb_read(32'h0C, 32'h81, 32'hFFFFFFFF);

        // START alone, then read 0x3C with ACK=1 (released)
        apb_write(32'h04, 32'hC0);
        apb_write(32'h14, 32'h01);
        smode = SM_RD; slv_data = 8'h3C;
        apb_write(32'h14, 32'h80);
        wait_tip(n);
        chk("tip_len_sta", n, 8);
        apb_read(32'h0C, 32'hC1, 32'hFFFFFFFF);
        chk("irq_after_sta", {31'h0, interrupt_o}, 32'h1);
        chk("scl_held_low", {31'h0, scl_padoen_o}, 32'h0);
        apb_write(32'h14, 32'h01);
        chk("irq_iack", {31'h0, interrupt_o}, 32'h0);
        bit_q.delete();
        push_bits(9'b0011_1100_1);
        apb_write(32'h14, 32'h28);
        wait_tip(n);
        chk("tip_len_rd", n, 72);
        chk("bits_left_rd", bit_q.size(), 0);
        apb_read(32'h08, 32'h3C, 32'hFFFFFFFF);
        chk("irq_rd", {31'h0, interrupt_o}, 32'h1);
        apb_write(32'h14, 32'h01);
        chk("irq_rd_iack", {31'h0, interrupt_o}, 32'h0);
        apb_read(32'h0C, 32'hC0, 32'hFFFFFFFF);

        // Disabled core ignores commands
        smode = SM_NONE;
        apb_write(32'h04, 32'h00);
        apb_write(32'h14, 32'h90);
        repeat (5) @(posedge clk);
        #1;
        chk("dis_scl_oen", {31'h0, scl_padoen_o}, 32'h1);
        chk("dis_sda_oen", {31'h0, sda_padoen_o}, 32'h1);
        apb_read(32'h0C, 32'h00, 32'h00000043);

        // Abort mid-byte by clearing EN
        apb_write(32'h04, 32'h80);
        apb_write(32'h00, 32'h3);
        apb_write(32'h10, 32'hFF);
        bit_q.delete();
        apb_write(32'h14, 32'h90);
        repeat (40) @(posedge clk);
        #1 PADDR = 32'h0C;
        #1 chk("mid_busy_tip", PRDATA & 32'h42, 32'h42);
        apb_write(32'h04, 32'h00);
        chk("abort_scl_oen", {31'h0, scl_padoen_o}, 32'h1);
        chk("abort_sda_oen", {31'h0, sda_padoen_o}, 32'h1);
        PADDR = 32'h0C;
        #1 chk("abort_status", PRDATA & 32'h43, 32'h0);
        @(posedge clk); #1;
        apb_read(32'h18, 32'h0, 32'hFFFFFFFF);
        apb_write(32'h18, 32'hFFFF);
        apb_read(32'h00, 32'h3, 32'hFFFFFFFF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/apb_i2c_ctrl.md
Name: apb_i2c_ctrl

Overview:
- APB-slave I2C master controller for the peripheral subsystem; one of the APB demux leaf targets.
- Software programs a prescaler, enables the core and issues byte-level commands (START/STOP/READ/WRITE).
- The block generates open-drain SCL/SDA waveforms and raises a level interrupt when each command completes.
- Single master: no clock stretching, no arbitration.

Parameters:
- APB_ADDR_WIDTH, 32, width of PADDR; only PADDR[4:2] is decoded.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low
- PADDR  in  APB_ADDR_WIDTH  APB address
- PWDATA  in  32  write data
- PWRITE  in  1  1 = write
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PRDATA  out  32  read data
- PREADY  out  1  tied 1
- PSLVERR  out  1  tied 0
- interrupt_o  out  1  IF & IEN
- scl_pad_i  in  1  SCL line level
- scl_pad_o  out  1  tied 0
- scl_padoen_o  out  1  0 = drive SCL low, 1 = release
- sda_pad_i  in  1  SDA line level
- sda_pad_o  out  1  tied 0
- sda_padoen_o  out  1  0 = drive SDA low, 1 = release

Behaviour:
- APB access:
  - Write strobe = PSEL & PENABLE & PWRITE.
  - Zero wait states.
  - PRDATA is combinational from PADDR[4:2]; unused bits read 0.
  - Unmapped addresses read 0; writes to them are ignored.
- Registers (byte offset):
  - 0x00 PRE [15:0] RW, reset 0xFFFF.
  - 0x04 CTR RW: [7] EN, [6] IEN; reset 0.
  - 0x08 RX [7:0] RO, reset 0.
  - 0x0C STATUS RO: [7] RxACK, [6] BUSY, [5] AL (always 0), [1] TIP, [0] IF; reset 0.
  - 0x10 TX [7:0] RW, reset 0.
  - 0x14 CMD WO (reads 0): [7] STA, [6] STO, [5] RD, [4] WR, [3] ACK, [0] IACK.
- Reset: all registers at reset values, TIP = 0, both padoen = 1, interrupt_o = 0.
- Timing: quarter-bit period Q = PRE+1 clk cycles. Every START, data bit, ACK bit and STOP occupies exactly 4 quarters.
- Command acceptance:
  - A CMD write with EN=1, TIP=0 and any of STA/STO/RD/WR set latches the command; TIP = 1 on the next cycle.
  - Otherwise STA/STO/RD/WR are ignored.
  - IACK is always honoured: it clears IF.
- Sequence: optional START → optional byte (WR takes priority if both RD and WR are set) → optional STOP.
- START quarters: q0 SDA released, SCL released; q1 SDA low; q2 SDA low, SCL released; q3 SCL low.
- Data bit quarters: q0 SCL low, SDA set; q1 SCL released; q2 SCL released, sample sda_pad_i; q3 SCL low.
- Bit order: 8 data bits MSB first, then 1 ACK bit.
- WR:
  - Drives TX[7..0] onto SDA.
  - Releases SDA in the ACK bit and stores the sampled value in RxACK.
- RD:
  - Releases SDA for all data bits and shifts samples into RX (RX updates when the byte completes).
  - Drives CMD.ACK in the ACK bit: 0 = ACK (drive low), 1 = release.
- STOP quarters: q0 SCL low, SDA low; q1 SCL released; q2 SDA released; q3 idle.
- Completion:
  - In the cycle after the last quarter ends: TIP = 0, IF = 1, lines left as at the end of the sequence.
  - SCL is held low between bytes unless STOP was issued.
- BUSY is set when a START completes and cleared when a STOP completes.
- IF vs IACK: if IACK is written in the same cycle IF is set by completion, IF ends at 1.
- EN cleared mid-transfer: on the next cycle abort, release both lines, TIP = 0, BUSY = 0, IF unchanged.
- Writes to PRE and TX during TIP take effect immediately; software must not do this.
- Reset asserted mid-operation returns the block to reset state on the next clock edge.

Test Plan:
- Reset, then read 0x00/0x04/0x08/0x0C/0x10/0x14 → 0xFFFF, 0, 0, 0, 0, 0; PREADY=1, PSLVERR=0 on every access.
- PRE=1, CTR=0x80, TX=0xA5, CMD=0xD0 (STA|STO|WR); slave model ACKs → TIP=1 for 44*2 = 88 cycles; SDA bits sampled at SCL high read 1,0,1,0,0,1,0,1; STATUS ends RxACK=0, BUSY=0, IF=1; lines released.
- Same write with no slave (SDA pulled high) → RxACK=1.
- CTR=0xC0, CMD=0x28 (RD|ACK) after a START; slave drives 0x3C → RX=0x3C; master releases SDA in the ACK bit; interrupt_o=1; CMD=0x01 → IF=0, interrupt_o=0.
- CTR=0x00, CMD=0x90 → TIP stays 0, pads stay released, IF stays 0.
- Mid-byte, write CTR=0x00 → next cycle TIP=0, both padoen=1; then read of 0x18 → 0.
